// File: rtl/sdr_tx_pkg.sv
// Shared SDR TX/RX definitions: frame sync bits, default test pattern,
// load-source select and the frame builder shared with the RX deframer.
package sdr_tx_pkg;

   localparam logic [1:0]  SYNC_I               = 2'b01;
   localparam logic [1:0]  SYNC_Q               = 2'b10;
   localparam int unsigned MAX_SAMPLE_W         = 32;
   localparam int unsigned MAX_FRAME_W          = 2 * (MAX_SAMPLE_W + 2);
   localparam logic [31:0] TEST_PATTERN_DEFAULT = 32'h7FFF_BFFF;

   typedef logic [MAX_FRAME_W-1:0] frame_t;

   typedef enum logic [1:0] {
      SRC_IDLE,
      SRC_TEST,
      SRC_DATA,
      SRC_UNDER
   } frame_src_e;

   // {SYNC_I, I, SYNC_Q, Q} right-aligned in a max-width word; optional
   // inversion covers the whole frame including the sync bits.
   function automatic frame_t build_frame(input logic [MAX_SAMPLE_W-1:0] i,
                                          input logic [MAX_SAMPLE_W-1:0] q,
                                          input int unsigned             sample_w,
                                          input logic                    invert);
      frame_t smask;
      frame_t fmask;
      frame_t f;
      smask = (frame_t'(1) << sample_w) - frame_t'(1);
      fmask = (frame_t'(1) << (2 * sample_w + 4)) - frame_t'(1);
      f     = (frame_t'(SYNC_I) << (2 * sample_w + 2))
            | ((frame_t'(i) & smask) << (sample_w + 2))
            | (frame_t'(SYNC_Q) << sample_w)
            | (frame_t'(q) & smask);
      if (invert) begin
         f = ~f;
      end
      return f & fmask;
   endfunction

endpackage

// File: rtl/sdr_iq_ddr_serializer_if.sv
// I/Q sample-pair handshake between the baseband source and the serializer.
interface sdr_iq_ddr_serializer_if #(
   parameter int unsigned SAMPLE_W = 14
);
   logic [SAMPLE_W-1:0] s_i;
   logic [SAMPLE_W-1:0] s_q;
   logic                s_valid;
   logic                s_ready;

   modport master (output s_i, output s_q, output s_valid, input s_ready);
   modport slave  (input s_i, input s_q, input s_valid, output s_ready);
endinterface

// File: rtl/ODDRX1F.sv
// Behavioural stand-in for the ECP5 ODDRX1F primitive, for simulation only;
// leave it out of the synthesis file list so the vendor cell is used.
// D0 is driven while SCLK is high, D1 while SCLK is low.
module ODDRX1F (
   input  logic D0,
   input  logic D1,
   input  logic SCLK,
   input  logic RST,
   output logic Q
);
   logic d0_q;
   logic d1_q;

   // Capture both data bits on the rising edge.
   always_ff @(posedge SCLK or posedge RST) begin
      if (RST) begin
         d0_q <= 1'b0;
         d1_q <= 1'b0;
      end else begin
         d0_q <= D0;
         d1_q <= D1;
      end
   end

   assign Q = SCLK ? d0_q : d1_q;

endmodule

// File: rtl/sdr_tx_fifo.sv
// Synchronous first-word-fall-through FIFO for sample pairs. rd_data always
// shows the oldest entry; pop consumes it. Push while full is dropped.
module sdr_tx_fifo #(
   parameter int unsigned WIDTH = 28,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_q == (AW + 1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign rd_data = mem_q[rd_ptr_q];

   // Pointer and occupancy update; refused push/pop leave state untouched.
   always_comb begin
      push_ok  = push & ~full;
      pop_ok   = pop & ~empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
   end

   // Control state, cleared on reset (contents become unreachable).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/sdr_iq_ddr_serializer.sv
// I/Q frame serializer: FIFO-buffered sample pairs are framed as
// {01, I, 10, Q} and shifted out MSB first, two bits per clk via ODDRX1F.
// A new frame is loaded every FRAME_W/2 clocks with no gaps.
module sdr_iq_ddr_serializer
   import sdr_tx_pkg::*;
#(
   parameter int unsigned         SAMPLE_W     = 14,
   parameter int unsigned         FIFO_DEPTH   = 8,
   parameter bit                  INVERT       = 1'b1,
   parameter frame_t              TEST_PATTERN = frame_t'(TEST_PATTERN_DEFAULT),
   parameter logic [SAMPLE_W-1:0] IDLE_I       = '0,
   parameter logic [SAMPLE_W-1:0] IDLE_Q       = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   sdr_iq_ddr_serializer_if.slave   s_if,
   input  logic                     enable,
   input  logic                     mode,
   input  logic                     clr_status,
   output logic                     frame_start,
   output logic                     underflow,
   output logic [15:0]              frame_cnt,
   output logic                     ddr_out
);
   localparam int unsigned FRAME_W = 2 * (SAMPLE_W + 2);
   localparam int unsigned HALF_W  = SAMPLE_W + 2;
   localparam int unsigned CNT_W   = $clog2(HALF_W);

   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(HALF_W - 1);
   localparam logic [FRAME_W-1:0] IDLE_FRAME =
      FRAME_W'(build_frame(MAX_SAMPLE_W'(IDLE_I), MAX_SAMPLE_W'(IDLE_Q), SAMPLE_W, INVERT));
   localparam logic [FRAME_W-1:0] TEST_FRAME =
      TEST_PATTERN[FRAME_W-1:0] ^ {FRAME_W{INVERT}};

   logic [FRAME_W-1:0]    shift_q, shift_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  frame_start_q, frame_start_d;
   logic                  underflow_q, underflow_d;
   logic [15:0]           frame_cnt_q, frame_cnt_d;
   logic                  ready_q, ready_d;

   logic                  load;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [2*SAMPLE_W-1:0] fifo_rd;
   logic [FRAME_W-1:0]    data_frame;
   frame_src_e            src;

   // s_ready held low through reset, then tracks registered occupancy.
   assign s_if.s_ready = ready_q & ~fifo_full;
   assign fifo_push    = s_if.s_valid & s_if.s_ready;

   sdr_tx_fifo #(
      .WIDTH (2 * SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (fifo_push),
      .wr_data ({s_if.s_i, s_if.s_q}),
      .pop     (fifo_pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Load-cycle source selection, frame mux, shift/count and status update.
   always_comb begin
      load          = (bit_cnt_q == '0);
      src           = SRC_IDLE;
      fifo_pop      = 1'b0;
      data_frame    = FRAME_W'(build_frame(MAX_SAMPLE_W'(fifo_rd[2*SAMPLE_W-1 -: SAMPLE_W]),
                                           MAX_SAMPLE_W'(fifo_rd[SAMPLE_W-1:0]),
                                           SAMPLE_W, INVERT));
      shift_d       = {shift_q[FRAME_W-3:0], 2'b00};
      bit_cnt_d     = bit_cnt_q - CNT_W'(1);
      frame_start_d = 1'b0;
      underflow_d   = underflow_q;
      frame_cnt_d   = frame_cnt_q;
      ready_d       = 1'b1;

      if (!enable) begin
         src = SRC_IDLE;
      end else if (mode) begin
         src = SRC_TEST;
      end else if (!fifo_empty) begin
         src = SRC_DATA;
      end else begin
         src = SRC_UNDER;
      end

      if (clr_status) begin
         underflow_d = 1'b0;
      end

      if (load) begin
         bit_cnt_d     = CNT_LAST;
         frame_start_d = 1'b1;
         case (src)
            SRC_TEST: shift_d = TEST_FRAME;
            SRC_DATA: begin
               shift_d     = data_frame;
               fifo_pop    = 1'b1;
               frame_cnt_d = frame_cnt_q + 16'd1;
            end
            SRC_UNDER: begin
               shift_d     = IDLE_FRAME;
               underflow_d = 1'b1;
            end
            default: shift_d = IDLE_FRAME;
         endcase
      end
   end

   // Serializer and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q       <= IDLE_FRAME;
         bit_cnt_q     <= CNT_LAST;
         frame_start_q <= 1'b0;
         underflow_q   <= 1'b0;
         frame_cnt_q   <= '0;
         ready_q       <= 1'b0;
      end else begin
         shift_q       <= shift_d;
         bit_cnt_q     <= bit_cnt_d;
         frame_start_q <= frame_start_d;
         underflow_q   <= underflow_d;
         frame_cnt_q   <= frame_cnt_d;
         ready_q       <= ready_d;
      end
   end

   assign frame_start = frame_start_q;
   assign underflow   = underflow_q;
   assign frame_cnt   = frame_cnt_q;

   ODDRX1F u_oddr (
      .D0   (shift_q[FRAME_W-1]),
      .D1   (shift_q[FRAME_W-2]),
      .SCLK (clk),
      .RST  (rst),
      .Q    (ddr_out)
   );

endmodule
